mdu_sequencer: RTL and testbench
================================

// Module: mdu_sequencer
// PURPOSE
// - Multi-cycle unsigned multiply/divide unit (MULTU/DIVU) for the MIPS core; owns no adder, borrows the shared ALU.
// - Idle: datapath ALU request passes straight through. Busy: drives ALU itself each cycle (ADD/SUB/LTU), asserts busy to stall.
// - Results land in hi/lo registers, held until the next accepted start.
// PARAMETERS
// - N  32  operand width; hi/lo each N bits; iteration counter is $clog2(N) bits
// PORTS
// - clock     in   1   sole clock, rising edge
// - reset_n   in   1   synchronous, active-low reset
// - start     in   1   accept op when high and busy==0
// - op        in   1   0=MULTU, 1=DIVU
// - op_a      in   N   multiplicand / dividend, sampled on accepted start
// - op_b      in   N   multiplier / divisor, sampled on accepted start
// - busy      out  1   high in every non-IDLE state
// - done      out  1   one-cycle pulse; hi/lo valid from this cycle on
// - hi, lo    out  N   MULTU: {hi,lo}=product; DIVU: lo=quotient, hi=remainder
// - dp_a, dp_b in  N   datapath ALU operands
// - dp_fn     in   5   datapath ALUfn
// - alu_a, alu_b out N shared ALU operands
// - alu_fn    out  5   shared ALU function {subtract,bool1,bool0,shft,math}
// - alu_r     in   N   shared ALU result (combinational, same cycle)
// BEHAVIOUR
// - Reset (reset_n==0 at edge): state=IDLE, busy=0, done=0, hi=lo=0, counter=0; aborts any op in flight, no done.
// - ALU mux: IDLE -> alu_{a,b,fn}=dp_{a,b,fn}; other states -> sequencer values. Combinational, no added latency.
// - ALUfn codes: ADD=5'b00001, SUB=5'b10001, LTU=5'b10111 (alu_r = {0..,A<B unsigned}).
// - Start ignored while busy. Start cycle = cycle 0: latch operands, go to STEP_A (or DIVZ).
// - FSM: IDLE -> STEP_A -> STEP_B -> (STEP_A if cnt!=N-1, else FINISH) -> IDLE; IDLE -> DIVZ -> IDLE.
// - Fixed latency: 2 cycles/bit, done in cycle 2N+1 (65 for N=32) in FINISH, then IDLE; no data-dependent early exit.
// - MULTU (right-shift shift-add, P={hi,lo}, lo preloaded with op_b, hi=0, mcand reg=op_a):
//   STEP_A: alu=ADD(hi, lo[0]?mcand:0), latch sum.  STEP_B: alu=LTU(sum, addend) -> carry (unsigned wrap);
//   then {hi,lo} <= {carry,sum,lo}>>1; cnt++.
// - DIVU (restoring, rem=hi=0, lo=dividend, dvsr reg=op_b):
//   entering STEP_A: {ovf,hi,lo} <= {hi,lo}<<1 (ovf = bit shifted out of hi).
//   STEP_A: alu=LTU(hi,dvsr) -> lt.  STEP_B: alu=SUB(hi,dvsr);
//   if (ovf | ~lt): hi<=alu_r, lo[0]<=1 else lo[0]<=0; cnt++. Subtraction modulo 2^N is exact when ovf=1.
// - Divide by zero (op=1, op_b==0): DIVZ for one cycle, ALU not used (pass-through stays), done in cycle 1,
//   lo=all-ones, hi=op_a.
// - Counter wraps N-1 -> 0 only on FINISH entry; done never asserted in same cycle as an accepted start.
// STRUCTURE
// - Package mdu_pkg: typedef enum {IDLE,STEP_A,STEP_B,FINISH,DIVZ} mdu_state_t; localparams ALUFN_ADD/SUB/LTU, OP_MULTU/OP_DIVU.
// - Single module; one FSM + hi/lo/aux registers; ALU mux inline. No sub-modules (ALU instantiated at top level).
// TESTING (bench instantiates ALU N=32 on alu_* ports)
// - MULTU 7 x 6 -> done pulse cycle 65, hi=0, lo=42; busy high cycles 1..65.
// - MULTU FFFFFFFF x FFFFFFFF -> hi=FFFFFFFE, lo=00000001 (carry path).
// - DIVU 100/7 -> lo=14, hi=2; DIVU FFFFFFFF/1 -> lo=FFFFFFFF, hi=0; DIVU 5/9 -> lo=0, hi=5.
// - DIVU 1234/0 -> done cycle 1, lo=FFFFFFFF, hi=1234; alu_fn equals dp_fn throughout.
// - Idle pass-through dp_a=3, dp_b=4, dp_fn=ADD -> alu_r=7 same cycle; start during busy -> ignored, result unchanged.
// - reset_n low at cycle 20 of a MULTU -> next cycle busy=0, done=0, hi=lo=0; new op then completes normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer.
// Contents: sequencer state type, shared-ALU function codes, operation codes.
package mdu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STEP_A,
    STEP_B,
    FINISH,
    DIVZ
  } mdu_state_t;

  // Shared ALU function encoding {subtract,bool1,bool0,shft,math}
  localparam logic [4:0] ALUFN_ADD = 5'b00001;
  localparam logic [4:0] ALUFN_SUB = 5'b10001;
  localparam logic [4:0] ALUFN_LTU = 5'b10111;

  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

endpackage

// File: rtl/mdu_sequencer.sv
// Multi-cycle unsigned multiply/divide unit (MULTU/DIVU). Owns no adder:
// while busy it borrows the shared ALU, otherwise the datapath request
// passes straight through to the ALU.
//
// Ports
//   clock, reset_n        rising-edge clock, synchronous active-low reset
//   start, op, op_a, op_b operation request (op: 0=MULTU, 1=DIVU)
//   busy, done            busy in every non-IDLE state; done pulses once
//   hi, lo                results (product, or remainder/quotient)
//   dp_a, dp_b, dp_fn     datapath ALU request
//   alu_a, alu_b, alu_fn  shared ALU request (muxed)
//   alu_r                 shared ALU result, combinational
//
// state  | meaning
// IDLE   | ALU passes datapath request through, waits for start
// STEP_A | MULTU: hi + addend; DIVU: compare hi < divisor
// STEP_B | MULTU: carry detect + shift; DIVU: conditional subtract + shift
// FINISH | results valid, done pulse
// DIVZ   | divide by zero, results forced, done pulse
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic         op,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  input  logic [N-1:0] dp_a,
  input  logic [N-1:0] dp_b,
  input  logic [4:0]   dp_fn,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [4:0]   alu_fn,
  input  logic [N-1:0] alu_r
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  mdu_state_t    state;
  logic [CW-1:0] cnt;
  logic          is_div;
  logic [N-1:0]  opnd;   // multiplicand or divisor
  logic [N-1:0]  sum;    // partial sum latched in STEP_A (MULTU)
  logic          lt;     // hi < divisor, latched in STEP_A (DIVU)
  logic          ovf;    // bit shifted out of hi on the last DIVU shift

  logic [N-1:0] addend;
  logic         div_take;
  logic [N-1:0] div_hi;
  logic [N-1:0] div_lo;

  assign addend   = lo[0] ? opnd : '0;
  // With ovf set the true remainder is >= 2^N > divisor, so the modulo
  // subtraction still yields the exact result.
  assign div_take = ovf | ~lt;
  assign div_hi   = div_take ? alu_r : hi;
  assign div_lo   = {lo[N-1:1], div_take};

  always_comb begin
    alu_a  = dp_a;
    alu_b  = dp_b;
    alu_fn = dp_fn;
    case (state)
      STEP_A: begin
        alu_a  = hi;
        alu_b  = is_div ? opnd : addend;
        alu_fn = is_div ? ALUFN_LTU : ALUFN_ADD;
      end
      STEP_B: begin
        alu_a  = is_div ? hi : sum;
        alu_b  = is_div ? opnd : addend;
        alu_fn = is_div ? ALUFN_SUB : ALUFN_LTU;
      end
      FINISH: begin
        alu_a  = hi;
        alu_b  = '0;
        alu_fn = ALUFN_ADD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      opnd   <= '0;
      sum    <= '0;
      lt     <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div <= op;
            opnd   <= (op == OP_DIVU) ? op_b : op_a;
            cnt    <= '0;
            ovf    <= 1'b0;
            busy   <= 1'b1;
            if (op == OP_DIVU && op_b == '0) begin
              hi    <= op_a;
              lo    <= '1;
              done  <= 1'b1;
              state <= DIVZ;
            end else if (op == OP_DIVU) begin
              // First left shift of {rem=0, dividend} happens on entry.
              hi    <= {{(N-1){1'b0}}, op_a[N-1]};
              lo    <= {op_a[N-2:0], 1'b0};
              state <= STEP_A;
            end else begin
              hi    <= '0;
              lo    <= op_b;
              state <= STEP_A;
            end
          end
        end
        STEP_A: begin
          if (is_div) lt <= alu_r[0];
          else        sum <= alu_r;
          state <= STEP_B;
        end
        STEP_B: begin
          cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= FINISH;
            done  <= 1'b1;
          end else begin
            state <= STEP_A;
          end
          if (is_div) begin
            if (cnt == CNT_LAST) begin
              hi <= div_hi;
              lo <= div_lo;
            end else begin
              {ovf, hi, lo} <= {div_hi, div_lo, 1'b0};
            end
          end else begin
            // alu_r[0] is the carry out of the STEP_A addition.
            hi <= {alu_r[0], sum[N-1:1]};
            lo <= {sum[0], lo[N-1:1]};
          end
        end
        FINISH, DIVZ: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: shared ALU modelled here, results compared
// against plain 64-bit multiply and integer divide/modulo.
module tb_mdu_sequencer;

  localparam logic [4:0] F_ADD = 5'b00001;
  localparam logic [4:0] F_SUB = 5'b10001;
  localparam logic [4:0] F_LTU = 5'b10111;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [31:0] dp_a = '0;
  logic [31:0] dp_b = '0;
  logic [4:0]  dp_fn = F_ADD;
  logic [31:0] alu_a, alu_b, alu_r;
  logic [4:0]  alu_fn;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mdu_sequencer #(.N(32)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .dp_a(dp_a), .dp_b(dp_b), .dp_fn(dp_fn),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn), .alu_r(alu_r)
  );

  // Shared ALU
  always_comb begin
    alu_r = '0;
    case (alu_fn)
      F_ADD:   alu_r = alu_a + alu_b;
      F_SUB:   alu_r = alu_a - alu_b;
      F_LTU:   alu_r = {31'b0, (alu_a < alu_b)};
      default: alu_r = '0;
    endcase
  end

  function automatic logic [4:0] rand_fn();
    case ($urandom_range(2))
      0:       return F_ADD;
      1:       return F_SUB;
      default: return F_LTU;
    endcase
  endfunction

  task automatic randomize_dp();
    dp_a  = $urandom;
    dp_b  = $urandom;
    dp_fn = rand_fn();
  endtask

  // One operation: start, wait for done, compare against arithmetic model.
  // inject_cyc > 0 raises a conflicting start in that busy cycle.
  task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                        input string name, input int inject_cyc);
    logic [63:0] p;
    logic [31:0] eh, el;
    int lat, cyc, done_cyc;
    bit busy_ok, pass_ok, divz;
    divz = 1'b0;
    if (o == 1'b0) begin
      p = 64'(a) * 64'(b);
      eh = p[63:32]; el = p[31:0]; lat = 2 * 32 + 1;
    end else if (b == 32'd0) begin
      eh = a; el = 32'hFFFF_FFFF; lat = 1; divz = 1'b1;
    end else begin
      eh = a % b; el = a / b; lat = 2 * 32 + 1;
    end
    op = o; op_a = a; op_b = b; start = 1'b1;
    @(negedge clock);
    start = 1'b0; op_a = $urandom; op_b = $urandom;
    cyc = 1; done_cyc = -1; busy_ok = 1'b1; pass_ok = 1'b1;
    while (cyc <= 200) begin
      if (done === 1'b1) begin
        done_cyc = cyc;
        if (busy !== 1'b1) busy_ok = 1'b0;
        if (alu_fn !== dp_fn || alu_a !== dp_a || alu_b !== dp_b) pass_ok = 1'b0;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (cyc == inject_cyc) begin
        start = 1'b1; op = ~o; op_a = $urandom; op_b = $urandom | 32'd1;
      end else begin
        start = 1'b0;
      end
      randomize_dp();
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (done_cyc !== lat) begin
      failures++;
      $display("FAIL %s done_cycle got %0d expected %0d", name, done_cyc, lat);
    end
    checks++;
    if (!busy_ok) begin
      failures++;
      $display("FAIL %s busy_window got low before done expected high cycles 1..%0d", name, lat);
    end
    checks++;
    if (hi !== eh || lo !== el) begin
      failures++;
      $display("FAIL %s result got hi=%08h lo=%08h expected hi=%08h lo=%08h", name, hi, lo, eh, el);
    end
    if (divz) begin
      checks++;
      if (!pass_ok) begin
        failures++;
        $display("FAIL %s divz_passthrough got alu_fn=%b dp_fn=%b", name, alu_fn, dp_fn);
      end
    end
    randomize_dp();
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL %s after_done got busy=%b done=%b expected 0 0", name, busy, done);
    end
    checks++;
    if (hi !== eh || lo !== el) begin
      failures++;
      $display("FAIL %s hold got hi=%08h lo=%08h expected hi=%08h lo=%08h", name, hi, lo, eh, el);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got busy=%b done=%b expected 0 0", busy, done);
    end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("FAIL reset_hilo got hi=%08h lo=%08h expected 0 0", hi, lo);
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_passthrough();
    logic [31:0] exp_r;
    dp_a = 32'd3; dp_b = 32'd4; dp_fn = F_ADD;
    #1;
    checks++;
    if (alu_r !== 32'd7 || alu_fn !== F_ADD) begin
      failures++;
      $display("FAIL passthrough_add got alu_r=%0d alu_fn=%b expected 7 %b", alu_r, alu_fn, F_ADD);
    end
    for (int i = 0; i < 6; i++) begin
      randomize_dp();
      if (i == 0) dp_b = dp_a;
      #1;
      case (dp_fn)
        F_ADD:   exp_r = dp_a + dp_b;
        F_SUB:   exp_r = dp_a - dp_b;
        default: exp_r = (dp_a < dp_b) ? 32'd1 : 32'd0;
      endcase
      checks++;
      if (alu_r !== exp_r || alu_a !== dp_a || alu_b !== dp_b) begin
        failures++;
        $display("FAIL passthrough_rand got alu_r=%08h expected %08h", alu_r, exp_r);
      end
    end
    @(negedge clock);
  endtask

  task automatic test_directed();
    run_op(1'b0, 32'd7, 32'd6, "multu_7x6", 0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 0);
    run_op(1'b1, 32'd100, 32'd7, "divu_100_7", 0);
    run_op(1'b1, 32'hFFFF_FFFF, 32'd1, "divu_max_1", 0);
    run_op(1'b1, 32'd5, 32'd9, "divu_5_9", 0);
    run_op(1'b1, 32'd1234, 32'd0, "divu_by_zero", 0);
    run_op(1'b1, 32'hFFFF_FFFF, 32'h8000_0001, "divu_ovf", 0);
  endtask

  task automatic test_start_while_busy();
    run_op(1'b0, 32'd123456, 32'd789, "busy_start_mul", 10);
    run_op(1'b1, 32'd99999, 32'd37, "busy_start_div", 40);
  endtask

  task automatic test_abort();
    bit saw_done;
    op = 1'b0; op_a = $urandom; op_b = $urandom; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 2; c <= 20; c++) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("FAIL abort got busy=%b done=%b hi=%08h lo=%08h expected all 0", busy, done, hi, lo);
    end
    reset_n = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL abort_quiet got busy/done activity after reset expected none");
    end
    run_op(1'b0, 32'd1000, 32'd3000, "after_abort", 0);
  endtask

  task automatic test_random();
    logic o;
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      o = 1'($urandom_range(1));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(3))
        0: b = 32'd0;
        1: b = b >> $urandom_range(31);
        2: a = a >> $urandom_range(31);
        default: ;
      endcase
      run_op(o, a, b, "random", 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_passthrough();
    test_directed();
    test_start_while_busy();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
